// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse bring-up sequencer: reset, BAT/ID check, enable, then STREAM; responses checked, timeouts retried.
// Define PS2_SAMPLE_RATE_EN to also program the sample rate (0xF3, SAMPLE_RATE) before enabling.
module ps2_mouse_init_seq #(
   parameter int RSP_TIMEOUT = 2_500_000,
   parameter int BAT_TIMEOUT = 50_000_000,
   parameter int MAX_RETRY   = 3
`ifdef PS2_SAMPLE_RATE_EN
   ,
   parameter logic [7:0] SAMPLE_RATE = 8'h64
`endif
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       reinit,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_done,
   input  logic       tx_err,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic       STREAM,
   output logic       FAIL,
   output logic [2:0] retry_cnt
);

   typedef enum logic [3:0] {
      ST_START,
      ST_SEND_RST,
      ST_WAIT_ACK_RST,
      ST_WAIT_BAT,
      ST_WAIT_ID,
`ifdef PS2_SAMPLE_RATE_EN
      ST_SEND_RATE_CMD,
      ST_WAIT_ACK_RC,
      ST_SEND_RATE_VAL,
      ST_WAIT_ACK_RV,
`endif
      ST_SEND_EN,
      ST_WAIT_ACK_EN,
      ST_STREAMING,
      ST_FAILED
   } state_t;

   state_t      r_state;
   logic [7:0]  r_tx_data;
   logic        r_tx_start;
   logic        r_stream;
   logic        r_fail;
   logic [2:0]  r_retry;
   logic [1:0]  r_resend;
   logic [25:0] r_tmo;

   logic        w_is_send;
   logic        w_is_ack;
   logic        w_is_wait;
   logic        w_match;
   logic        w_resend;
   logic        w_tmo;
   logic        w_err;
   logic [7:0]  w_exp;
   logic [25:0] w_lim;

   always_comb begin
      w_is_send = 1'b0;
      w_is_ack  = 1'b0;
      w_exp     = 8'hFA;
      w_lim     = 26'(RSP_TIMEOUT - 1);
      case (r_state)
         ST_SEND_RST, ST_SEND_EN:         w_is_send = 1'b1;
         ST_WAIT_ACK_RST, ST_WAIT_ACK_EN: w_is_ack  = 1'b1;
`ifdef PS2_SAMPLE_RATE_EN
         ST_SEND_RATE_CMD, ST_SEND_RATE_VAL: w_is_send = 1'b1;
         ST_WAIT_ACK_RC, ST_WAIT_ACK_RV:     w_is_ack  = 1'b1;
`endif
         ST_WAIT_BAT: begin
            w_exp = 8'hAA;
            w_lim = 26'(BAT_TIMEOUT - 1);
         end
         ST_WAIT_ID: w_exp = 8'h00;
         default: ;
      endcase
      w_is_wait = w_is_ack | (r_state == ST_WAIT_BAT) | (r_state == ST_WAIT_ID);
      w_match   = (rx_data == w_exp);
      // A third 0xFE for the same command is treated as a plain mismatch.
      w_resend  = w_is_ack & (rx_data == 8'hFE) & (r_resend != 2'd2);
      w_tmo     = (r_tmo == w_lim);
      w_err     = (w_is_send & tx_err) |
                  (w_is_wait & (rx_err | (rx_valid & ~w_match & ~w_resend) | (~rx_valid & w_tmo)));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= ST_START;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
         r_stream   <= 1'b0;
         r_fail     <= 1'b0;
         r_retry    <= 3'd0;
         r_resend   <= 2'd0;
         r_tmo      <= 26'd0;
      end else begin
         r_tx_start <= 1'b0;
         r_tmo      <= r_tmo + 26'd1;
         if (reinit) begin
            r_state  <= ST_START;
            r_stream <= 1'b0;
            r_fail   <= 1'b0;
            r_retry  <= 3'd0;
            r_resend <= 2'd0;
            r_tmo    <= 26'd0;
         end else if (w_err) begin
            r_resend <= 2'd0;
            r_tmo    <= 26'd0;
            if (r_retry == 3'(MAX_RETRY)) begin
               r_state <= ST_FAILED;
               r_fail  <= 1'b1;
            end else begin
               r_retry <= r_retry + 3'd1;
               r_state <= ST_START;
            end
         end else begin
            // Every path into a SEND state also loads the byte and pulses tx_start.
            case (r_state)
               ST_START: begin
                  r_state    <= ST_SEND_RST;
                  r_tx_start <= 1'b1;
                  r_tx_data  <= 8'hFF;
                  r_tmo      <= 26'd0;
               end
               ST_SEND_RST: if (tx_done) begin
                  r_state <= ST_WAIT_ACK_RST;
                  r_tmo   <= 26'd0;
               end
               ST_WAIT_ACK_RST: if (rx_valid) begin
                  r_tmo <= 26'd0;
                  if (w_resend) begin
                     r_resend   <= r_resend + 2'd1;
                     r_state    <= ST_SEND_RST;
                     r_tx_start <= 1'b1;
                     r_tx_data  <= 8'hFF;
                  end else begin
                     r_resend <= 2'd0;
                     r_state  <= ST_WAIT_BAT;
                  end
               end
               ST_WAIT_BAT: if (rx_valid) begin
                  r_state <= ST_WAIT_ID;
                  r_tmo   <= 26'd0;
               end
               ST_WAIT_ID: if (rx_valid) begin
                  r_tmo      <= 26'd0;
                  r_tx_start <= 1'b1;
`ifdef PS2_SAMPLE_RATE_EN
                  r_state    <= ST_SEND_RATE_CMD;
                  r_tx_data  <= 8'hF3;
`else
                  r_state    <= ST_SEND_EN;
                  r_tx_data  <= 8'hF4;
`endif
               end
`ifdef PS2_SAMPLE_RATE_EN
               ST_SEND_RATE_CMD: if (tx_done) begin
                  r_state <= ST_WAIT_ACK_RC;
                  r_tmo   <= 26'd0;
               end
               ST_WAIT_ACK_RC: if (rx_valid) begin
                  r_tmo      <= 26'd0;
                  r_tx_start <= 1'b1;
                  if (w_resend) begin
                     r_resend  <= r_resend + 2'd1;
                     r_state   <= ST_SEND_RATE_CMD;
                     r_tx_data <= 8'hF3;
                  end else begin
                     r_resend  <= 2'd0;
                     r_state   <= ST_SEND_RATE_VAL;
                     r_tx_data <= SAMPLE_RATE;
                  end
               end
               ST_SEND_RATE_VAL: if (tx_done) begin
                  r_state <= ST_WAIT_ACK_RV;
                  r_tmo   <= 26'd0;
               end
               ST_WAIT_ACK_RV: if (rx_valid) begin
                  r_tmo      <= 26'd0;
                  r_tx_start <= 1'b1;
                  if (w_resend) begin
                     r_resend  <= r_resend + 2'd1;
                     r_state   <= ST_SEND_RATE_VAL;
                     r_tx_data <= SAMPLE_RATE;
                  end else begin
                     r_resend  <= 2'd0;
                     r_state   <= ST_SEND_EN;
                     r_tx_data <= 8'hF4;
                  end
               end
`endif
               ST_SEND_EN: if (tx_done) begin
                  r_state <= ST_WAIT_ACK_EN;
                  r_tmo   <= 26'd0;
               end
               ST_WAIT_ACK_EN: if (rx_valid) begin
                  r_tmo <= 26'd0;
                  if (w_resend) begin
                     r_resend   <= r_resend + 2'd1;
                     r_state    <= ST_SEND_EN;
                     r_tx_start <= 1'b1;
                     r_tx_data  <= 8'hF4;
                  end else begin
                     r_resend <= 2'd0;
                     r_state  <= ST_STREAMING;
                     r_stream <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign tx_data   = r_tx_data;
   assign tx_start  = r_tx_start;
   assign STREAM    = r_stream;
   assign FAIL      = r_fail;
   assign retry_cnt = r_retry;

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Directed bench for ps2_mouse_init_seq: scoreboard of expected command bytes plus state checks.
`timescale 1ns/1ps
module tb_ps2_mouse_init_seq;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       reinit = 1'b0;
   logic       tx_done = 1'b0;
   logic       tx_err = 1'b0;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       STREAM;
   logic       FAIL;
   logic [2:0] retry_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int n_tx     = 0;
   int n_exp    = 0;
   logic [7:0] q_tx[$];

   always #5 CLK = ~CLK;

   ps2_mouse_init_seq #(.RSP_TIMEOUT(100), .BAT_TIMEOUT(200), .MAX_RETRY(3)) dut (
      .CLK(CLK), .RST(RST), .reinit(reinit),
      .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .tx_err(tx_err),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
      .STREAM(STREAM), .FAIL(FAIL), .retry_cnt(retry_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every tx_start must match the next queued command byte.
   always @(negedge CLK) begin
      if (!RST && tx_start) begin
         n_tx++;
         if (q_tx.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
         else check("tx_byte", {24'h0, tx_data}, {24'h0, q_tx.pop_front()});
      end
   end

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic expect_tx(input logic [7:0] b);
      q_tx.push_back(b);
      n_exp++;
   endtask

   task automatic wait_tx(input string tag);
      int k = 0;
      while (n_tx < n_exp && k < 400) begin
         step();
         k++;
      end
      check(tag, 32'(n_tx), 32'(n_exp));
   endtask

   task automatic tx_ok();
      wait_tx("tx_seen");
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic pulse_reinit();
      reinit = 1'b1;
      step();
      reinit = 1'b0;
   endtask

   // Starts with 0xFF already sent; leaves the DUT waiting for the enable ACK.
   task automatic after_rst_sent();
      rx(8'hFA);
      rx(8'hAA);
`ifdef PS2_SAMPLE_RATE_EN
      expect_tx(8'hF3); rx(8'h00); tx_ok();
      expect_tx(8'h64); rx(8'hFA); tx_ok();
      expect_tx(8'hF4); rx(8'hFA); tx_ok();
`else
      expect_tx(8'hF4); rx(8'h00); tx_ok();
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values and first command
      expect_tx(8'hFF);
      repeat (3) step();
      check("rst_tx_start", {31'h0, tx_start}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h00);
      check("rst_stream", {31'h0, STREAM}, 32'h0);
      check("rst_fail", {31'h0, FAIL}, 32'h0);
      check("rst_retry", {29'h0, retry_cnt}, 32'h0);
      RST = 1'b0;
      step();
      check("first_tx_start", {31'h0, tx_start}, 32'h1);
      check("first_tx_data", {24'h0, tx_data}, 32'hFF);

      // Good bring-up, with a stale byte during SEND_RST
      rx(8'h00);
      tx_ok();
      after_rst_sent();
      check("good_stream_before", {31'h0, STREAM}, 32'h0);
      rx(8'hFA);
      check("good_stream", {31'h0, STREAM}, 32'h1);
      check("good_fail", {31'h0, FAIL}, 32'h0);
      check("good_retry", {29'h0, retry_cnt}, 32'h0);

      // reinit from STREAMING, then bad BAT byte
      expect_tx(8'hFF);
      pulse_reinit();
      check("reinit_stream_drop", {31'h0, STREAM}, 32'h0);
      check("reinit_retry", {29'h0, retry_cnt}, 32'h0);
      tx_ok();
      rx(8'hFA);
      expect_tx(8'hFF);
      rx(8'hFC);
      check("badbat_retry", {29'h0, retry_cnt}, 32'h1);
      tx_ok();
      after_rst_sent();
      rx(8'hFA);
      check("badbat_stream", {31'h0, STREAM}, 32'h1);
      check("badbat_retry_kept", {29'h0, retry_cnt}, 32'h1);

      // Two resends of enable are free
      expect_tx(8'hFF);
      pulse_reinit();
      tx_ok();
      after_rst_sent();
      expect_tx(8'hF4); rx(8'hFE); tx_ok();
      expect_tx(8'hF4); rx(8'hFE); tx_ok();
      rx(8'hFA);
      check("resend2_stream", {31'h0, STREAM}, 32'h1);
      check("resend2_retry", {29'h0, retry_cnt}, 32'h0);

      // Third resend counts as an error
      expect_tx(8'hFF);
      pulse_reinit();
      tx_ok();
      after_rst_sent();
      expect_tx(8'hF4); rx(8'hFE); tx_ok();
      expect_tx(8'hF4); rx(8'hFE); tx_ok();
      expect_tx(8'hFF);
      rx(8'hFE);
      check("resend3_retry", {29'h0, retry_cnt}, 32'h1);
      wait_tx("resend3_restart");

      // tx_err wins over a simultaneous tx_done on the last command byte
      expect_tx(8'hFF);
      pulse_reinit();
      tx_ok();
      rx(8'hFA);
      rx(8'hAA);
`ifdef PS2_SAMPLE_RATE_EN
      expect_tx(8'hF3); rx(8'h00); tx_ok();
      expect_tx(8'h64); rx(8'hFA); wait_tx("txerr_rate_seen");
`else
      expect_tx(8'hF4); rx(8'h00); wait_tx("txerr_en_seen");
`endif
      expect_tx(8'hFF);
      tx_err  = 1'b1;
      tx_done = 1'b1;
      step();
      tx_err  = 1'b0;
      tx_done = 1'b0;
      check("txerr_retry", {29'h0, retry_cnt}, 32'h1);
      check("txerr_stream", {31'h0, STREAM}, 32'h0);
      wait_tx("txerr_restart");

      // Silent mouse: four FF attempts, then FAIL
      expect_tx(8'hFF);
      pulse_reinit();
      for (int i = 0; i < 4; i++) begin
         wait_tx("tmo_tx");
         check("tmo_retry", {29'h0, retry_cnt}, 32'(i));
         if (i < 3) expect_tx(8'hFF);
         tx_done = 1'b1;
         step();
         tx_done = 1'b0;
      end
      repeat (50) step();
      check("tmo_fail_early", {31'h0, FAIL}, 32'h0);
      repeat (100) step();
      check("tmo_fail", {31'h0, FAIL}, 32'h1);
      check("tmo_retry_final", {29'h0, retry_cnt}, 32'h3);
      check("tmo_stream", {31'h0, STREAM}, 32'h0);
      repeat (20) step();

      // reinit from FAILED
      expect_tx(8'hFF);
      pulse_reinit();
      check("reinit_fail_drop", {31'h0, FAIL}, 32'h0);
      check("reinit_fail_retry", {29'h0, retry_cnt}, 32'h0);
      wait_tx("reinit_fail_tx");

      repeat (5) step();
      check("tx_queue_empty", 32'(q_tx.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
